// File: rtl/btb_pkg.sv
// Shared types for the BTB port scheduler: sweep/run state, queued update entry layout
// and default table geometry.
package btb_pkg;

  localparam int ENTRY_BIT_DEFAULT = 5;
  localparam int TAG_BIT           = 32 - ENTRY_BIT_DEFAULT - 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        is_branch;
    logic        taken;
  } upd_entry_t;

endpackage

// File: rtl/upd_fifo.sv
// Synchronous FIFO holding resolved control-flow updates until the BTB port is free.
// Storage is not reset; only pointers and occupancy are.
module upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 66
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/btb_port_scheduler.sv
// Arbitrates the single BTB port between IF lookups and queued EX updates, sweeps the
// table invalid after reset and guarantees updates drain under back-to-back lookups.
module btb_port_scheduler
  import btb_pkg::*;
#(
  parameter int ENTRY_BIT    = ENTRY_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          lookup_req,
  input  logic [31:0]                   lookup_pc,
  output logic                          lookup_grant,
  input  logic                          upd_valid,
  input  logic [31:0]                   upd_pc,
  input  logic [31:0]                   upd_target,
  input  logic                          upd_is_branch,
  input  logic                          upd_taken,
  output logic                          upd_ready,
  output logic                          tbl_en,
  output logic                          tbl_we,
  output logic [ENTRY_BIT-1:0]          tbl_idx,
  output logic                          tbl_wvalid,
  output logic                          tbl_wis_branch,
  output logic [32-ENTRY_BIT-3:0]       tbl_wtag,
  output logic [31:0]                   tbl_wtarget,
  output logic                          ctr_update,
  output logic                          ctr_taken,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);

  localparam int                   SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]        STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [ENTRY_BIT-1:0] SWEEP_LAST = '1;

  state_e                 state_q, state_d;
  logic [ENTRY_BIT-1:0]   sweep_q, sweep_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic                   init_done_q, init_done_d;
  upd_entry_t             push_entry, head;
  logic [$bits(upd_entry_t)-1:0] fifo_dout;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop, write_sel, lookup_win;
  logic                   unused_bits;

  assign push_entry = '{pc: upd_pc, target: upd_target,
                        is_branch: upd_is_branch, taken: upd_taken};
  assign head       = upd_entry_t'(fifo_dout);

  // Ready looks only at the registered count, so a full queue stays closed even while popping.
  assign upd_ready  = (state_q == RUN) && !fifo_full;
  assign push       = upd_valid && upd_ready;
  assign write_sel  = (state_q == RUN) && !fifo_empty &&
                      (fifo_full || !lookup_req || (starve_q == STARVE_MAX));
  assign lookup_win = (state_q == RUN) && lookup_req && !write_sel;
  assign pop        = write_sel;
  assign init_done  = init_done_q;

  assign unused_bits = ^{lookup_pc[1:0], lookup_pc[31:ENTRY_BIT+2], head.pc[1:0]};

  upd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(upd_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (fifo_dout),
    .count (pending),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      starve_q    <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      starve_q    <= starve_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    starve_d    = starve_q;
    init_done_d = init_done_q;
    case (state_q)
      INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == SWEEP_LAST) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        // Count only cycles where a queued update lost to a lookup.
        if (fifo_empty || write_sel) begin
          starve_d = '0;
        end else if (lookup_win && (starve_q != STARVE_MAX)) begin
          starve_d = starve_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    lookup_grant   = 1'b0;
    tbl_en         = 1'b0;
    tbl_we         = 1'b0;
    tbl_idx        = '0;
    tbl_wvalid     = 1'b0;
    tbl_wis_branch = 1'b0;
    tbl_wtag       = '0;
    tbl_wtarget    = '0;
    ctr_update     = 1'b0;
    ctr_taken      = 1'b0;
    if (state_q == INIT) begin
      tbl_en  = 1'b1;
      tbl_we  = 1'b1;
      tbl_idx = sweep_q;
    end else if (write_sel) begin
      tbl_en         = 1'b1;
      tbl_we         = 1'b1;
      tbl_idx        = head.pc[ENTRY_BIT+1:2];
      tbl_wvalid     = 1'b1;
      tbl_wis_branch = head.is_branch;
      tbl_wtag       = head.pc[31:ENTRY_BIT+2];
      tbl_wtarget    = head.target;
      ctr_update     = head.is_branch;
      ctr_taken      = head.is_branch && head.taken;
    end else if (lookup_win) begin
      lookup_grant = 1'b1;
      tbl_en       = 1'b1;
      tbl_idx      = lookup_pc[ENTRY_BIT+1:2];
    end
  end

endmodule
